// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: turns a cmd/rsp handshake into one
// AXI-lite write (AW+W, then B) or read (AR, then R) transaction at a time.
module axi_lite_master #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic [ADDR_WD-1:0] awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [DATA_WD-1:0] wdata,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic [ADDR_WD-1:0] araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [DATA_WD-1:0] rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_e;

  typedef struct packed {
    logic [DATA_WD-1:0] rdata;
    logic [1:0]         resp;
  } rsp_t;

  state_e             state_q, state_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WD-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  rsp_t               rsp_q, rsp_d;
  logic               aw_fire, w_fire;

  // Every handshake output decodes registered state only, so none of them
  // depends combinationally on its ready and all drop with async reset.
  assign cmd_ready = (state_q == IDLE);
  assign awvalid   = (state_q == WADDR) && !aw_done_q;
  assign wvalid    = (state_q == WADDR) && !w_done_q;
  assign bready    = (state_q == WRESP);
  assign arvalid   = (state_q == RADDR);
  assign rready    = (state_q == RDATA);
  assign rsp_valid = (state_q == RSP);
  assign awaddr    = awaddr_q;
  assign wdata     = wdata_q;
  assign araddr    = araddr_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_resp  = rsp_q.resp;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    rsp_d     = rsp_q;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d = cmd_addr;
            wdata_d  = cmd_wdata;
            state_d  = WADDR;
          end else begin
            araddr_d = cmd_addr;
            state_d  = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W complete independently; either order or the same edge.
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
          rsp_d.rdata = '0;
          rsp_d.resp  = bresp;
          state_d     = RSP;
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
          rsp_d.rdata = rdata;
          rsp_d.resp  = rresp;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      rsp_q     <= rsp_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI-lite slave with programmable or
// random readys, a scoreboard of expected responses, and directed timing checks.
module tb_axi_lite_master;
  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [7:0] awaddr, wdata, araddr, rdata;
  logic       awvalid, awready, wvalid, wready, bvalid, bready;
  logic       arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_master #(.DATA_WD(8), .ADDR_WD(8)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_vec = 0, n_mis = 0;
  int n_cmd = 0, n_rsp = 0;
  logic [9:0] sb[$];
  logic [7:0] model_mem [256];

  // slave knobs
  bit         rnd = 0;
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0, rsp_hold = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // handshakes that completed at the last posedge
  logic       awf, wf, bf, arf, rf;
  logic [7:0] s_awaddr, s_wdata, s_araddr;
  always @(posedge clk) begin
    awf <= awvalid && awready;  wf <= wvalid && wready;  bf <= bvalid && bready;
    arf <= arvalid && arready;  rf <= rvalid && rready;
    s_awaddr <= awaddr;  s_wdata <= wdata;  s_araddr <= araddr;
  end

  // slave model, drives 1 time unit after each posedge
  initial begin : slave
    logic [7:0] mem [256];
    logic [7:0] wa, wd, ra;
    bit have_aw, have_w, have_ar;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h66;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    have_aw = 0; have_w = 0; have_ar = 0; wa = 0; wd = 0; ra = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        have_aw = 0; have_w = 0; have_ar = 0; bvalid = 0; rvalid = 0;
        awready = 0; wready = 0; arready = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        continue;
      end
      if (awf) begin have_aw = 1; wa = s_awaddr; end
      if (wf)  begin have_w = 1;  wd = s_wdata;  end
      if (arf) begin have_ar = 1; ra = s_araddr; end
      if (bf) bvalid = 0;
      if (rf) rvalid = 0;
      if (have_aw && have_w && !bvalid) begin
        if (b_cnt >= b_dly && (!rnd || $urandom_range(0, 1) == 1)) begin
          mem[wa] = wd; bvalid = 1; bresp = bresp_cfg;
          have_aw = 0; have_w = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (have_ar && !rvalid) begin
        if (r_cnt >= r_dly && (!rnd || $urandom_range(0, 1) == 1)) begin
          rdata = mem[ra]; rresp = rresp_cfg; rvalid = 1; have_ar = 0; r_cnt = 0;
        end else r_cnt++;
      end
      awready = rnd ? 1'($urandom_range(0, 1)) : (awvalid && aw_cnt >= aw_dly);
      wready  = rnd ? 1'($urandom_range(0, 1)) : (wvalid && w_cnt >= w_dly);
      arready = rnd ? 1'($urandom_range(0, 1)) : (arvalid && ar_cnt >= ar_dly);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
    end
  end

  // response side: drives rsp_ready and pops the scoreboard on each rsp fire
  initial begin : monitor
    int  hold;
    bit  chk_idle;
    logic [9:0] e;
    hold = 0; chk_idle = 0; rsp_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (chk_idle) begin chk("idle_after_rsp", 32'(cmd_ready), 32'd1); chk_idle = 0; end
      if (!rstn) begin hold = 0; rsp_ready = 1; continue; end
      if (rsp_valid) begin
        rsp_ready = rnd ? 1'($urandom_range(0, 1)) : (hold >= rsp_hold);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(sb.size()), 32'd1);
          continue;
        end
        e = sb[0];
        if (!rsp_ready) begin
          hold++;
          if (rsp_hold > 0) begin
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_rdata", 32'(rsp_rdata), 32'(e[9:2]));
            chk("hold_resp", 32'(rsp_resp), 32'(e[1:0]));
          end
        end else begin
          void'(sb.pop_front());
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e[9:2]));
          chk("rsp_resp", 32'(rsp_resp), 32'(e[1:0]));
          n_rsp++; hold = 0; chk_idle = 1;
        end
      end else begin
        hold = 0;
        rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Issue one command; returns 1 time unit after the edge where it fired.
  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic [1:0] ers, input bit push);
    int t = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && t < 300) begin step(); t++; end
    if (!cmd_ready) chk("cmd_timeout", 32'(cmd_ready), 32'd1);
    if (push) begin
      sb.push_back({er, ers});
      n_cmd++;
      if (w) model_mem[a] = d;
    end
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(cmd_ready && sb.size() == 0) && t < 2000) begin step(); t++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin : main
    int c_aw, c_w, c_b, c_ar;
    logic [7:0] a, d, b;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h66;
    rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    repeat (3) step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    chk("rst_data", 32'({awaddr, wdata, araddr, rsp_rdata, rsp_resp}), 32'd0);
    rstn = 1;
    repeat (2) step();

    // zero-wait write: cycle-exact timing
    do_cmd(1, 8'h10, 8'hA5, 8'h00, 2'b00, 1);
    chk("w0_valids", 32'({awvalid, wvalid, cmd_ready}), 32'b110);
    chk("w0_awaddr", 32'(awaddr), 32'h10);
    chk("w0_wdata", 32'(wdata), 32'hA5);
    step();
    chk("w1_state", 32'({awvalid, wvalid, bready, rsp_valid}), 32'b0010);
    step();
    chk("w2_state", 32'({bready, rsp_valid}), 32'b01);
    step();
    chk("w3_cmd_ready", 32'(cmd_ready), 32'd1);
    wait_idle();

    // wready delayed: AW completes first, W waits with stable data
    w_dly = 3;
    do_cmd(1, 8'h44, 8'hC3, 8'h00, 2'b00, 1);
    c_aw = 0; c_w = 0; c_b = 0;
    for (int i = 0; i < 8; i++) begin
      if (awvalid) c_aw++;
      if (wvalid) begin c_w++; chk("w_dly_wdata", 32'(wdata), 32'hC3); end
      if (bready) c_b++;
      step();
    end
    chk("w_dly_aw_cycles", 32'(c_aw), 32'd1);
    chk("w_dly_w_cycles", 32'(c_w), 32'd4);
    chk("w_dly_b_cycles", 32'(c_b), 32'd1);
    wait_idle();
    w_dly = 0;

    // delayed read with SLVERR passed through
    ar_dly = 2; r_dly = 3; rresp_cfg = 2'b10;
    do_cmd(0, 8'h3C, 8'h00, 8'h5A, 2'b10, 1);
    c_ar = 0;
    for (int i = 0; i < 12; i++) begin
      if (arvalid) begin c_ar++; chk("r_araddr", 32'(araddr), 32'h3C); end
      step();
    end
    chk("r_ar_cycles", 32'(c_ar), 32'd3);
    wait_idle();
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00;

    // response back-pressure for 5 cycles, write with DECERR
    rsp_hold = 5; bresp_cfg = 2'b11;
    do_cmd(1, 8'h20, 8'h77, 8'h00, 2'b11, 1);
    wait_idle();
    rsp_hold = 0; bresp_cfg = 2'b00;
    do_cmd(0, 8'h20, 8'h00, 8'h77, 2'b00, 1);
    wait_idle();

    // random readys, alternating write/read
    rnd = 1;
    for (int i = 0; i < 128; i++) begin
      a = 8'($urandom_range(0, 255)); d = 8'($urandom);
      do_cmd(1, a, d, 8'h00, 2'b00, 1);
      b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 255));
      do_cmd(0, b, 8'h00, model_mem[b], 2'b00, 1);
    end
    wait_idle();
    rnd = 0;
    repeat (3) step();
    chk("rsp_count", 32'(n_rsp), 32'(n_cmd));

    // reset in the middle of a stalled write: no response may follow
    aw_dly = 10; w_dly = 10;
    do_cmd(1, 8'h55, 8'h99, 8'h00, 2'b00, 0);
    chk("abort_awvalid", 32'({awvalid, wvalid}), 32'b11);
    step();
    #3 rstn = 0;
    #1;
    chk("abort_valids", 32'({awvalid, wvalid, rsp_valid}), 32'b000);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) step();
    #3 rstn = 1;
    aw_dly = 0; w_dly = 0;
    repeat (20) step();
    chk("abort_no_rsp", 32'(n_rsp), 32'(n_cmd));
    do_cmd(0, 8'h55, 8'h00, model_mem[8'h55], 2'b00, 1);
    wait_idle();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
